// File: rtl/fc_in_buffer.sv
// Double-buffered serial-to-parallel collector feeding the FC layer.
// One bank fills from the beat stream while the other holds a complete frame on x.
//
//  state | meaning
//  EMPTY | no complete frame held, x gated to zero, accepting beats
//  ONE   | one frame presented on x, other bank filling
//  TWO   | both banks full, upstream stalled until the consumer releases
module fc_in_buffer #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [IN],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err_len
);

  localparam int CW = $clog2(IN);
  localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             state;
  logic [CW-1:0]    wr_cnt;
  logic             wr_sel;
  logic             rd_sel;
  logic [WIDTH-1:0] bank0 [IN];
  logic [WIDTH-1:0] bank1 [IN];

  logic accept;
  logic at_last;
  logic frame_end;
  logic len_err;
  logic release_f;

  assign accept    = s_valid & s_ready;
  assign at_last   = (wr_cnt == LAST_IDX);
  assign frame_end = accept & s_last & at_last;
  assign len_err   = accept & (s_last ^ at_last);
  assign release_f = x_valid & x_ready;

  // Frame storage has no reset; a stale bank is never visible because x is gated by x_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_sel) bank1[wr_cnt] <= s_data;
      else        bank0[wr_cnt] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      wr_cnt  <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      s_ready <= 1'b0;
      x_valid <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= len_err;
      if (accept) begin
        if (frame_end || len_err) wr_cnt <= '0;
        else                      wr_cnt <= wr_cnt + CW'(1);
      end
      if (frame_end) wr_sel <= ~wr_sel;
      if (release_f) rd_sel <= ~rd_sel;

      unique case (state)
        EMPTY: begin
          s_ready <= 1'b1;
          x_valid <= frame_end;
          if (frame_end) state <= ONE;
        end
        ONE: begin
          if (frame_end && !release_f) begin
            state   <= TWO;
            s_ready <= 1'b0;
            x_valid <= 1'b1;
          end else if (release_f && !frame_end) begin
            state   <= EMPTY;
            s_ready <= 1'b1;
            x_valid <= 1'b0;
          end else begin
            s_ready <= 1'b1;
            x_valid <= 1'b1;
          end
        end
        TWO: begin
          s_ready <= release_f;
          x_valid <= 1'b1;
          if (release_f) state <= ONE;
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b0;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < IN; i++) begin
      x[i] = '0;
      if (x_valid) x[i] = rd_sel ? bank1[i] : bank0[i];
    end
  end

endmodule

// File: tb/tb_fc_in_buffer.sv
// Scoreboard bench for fc_in_buffer: the driver models frames as beat lists, the monitor
// checks occupancy, x contents and length-error pulses every cycle.
module tb_fc_in_buffer;
  localparam int WIDTH = 8;
  localparam int IN    = 400;

  typedef logic [WIDTH-1:0] frame_t [IN];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic [WIDTH-1:0] x [IN];
  logic             x_valid;
  logic             x_ready = 1'b0;
  logic             err_len;

  // driver-owned model state
  frame_t           exp_q[$];
  logic [WIDTH-1:0] cur[$];
  int               err_exp = 0;
  int               timeouts = 0;
  bit               gaps = 0;
  bit               rnd_done = 0;
  bit               final_req = 0;

  // monitor-owned state
  int  rd_idx = 0;
  int  err_got = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  final_done = 0;
  logic rst_q = 1'b1;

  always #5 clk = ~clk;

  fc_in_buffer #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x(x), .x_valid(x_valid), .x_ready(x_ready), .err_len(err_len)
  );

  always @(posedge clk) rst_q <= rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name, input frame_t exp);
    int bad;
    bad = -1;
    for (int i = 0; i < IN; i++)
      if (x[i] !== exp[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: x[%0d] got %0h, expected %0h at %0t", name, bad, x[bad], exp[bad], $time);
    end
  endtask

  always @(negedge clk) begin
    frame_t f;
    int occ;
    if (rst_q) begin
      rd_idx  = exp_q.size();
      err_got = err_exp;
      for (int i = 0; i < IN; i++) f[i] = '0;
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_x_valid", 32'(x_valid), 32'(0));
      check("rst_err_len", 32'(err_len), 32'(0));
      check_frame("rst_x_zero", f);
    end else begin
      occ = exp_q.size() - rd_idx;
      check("s_ready", 32'(s_ready), 32'(occ < 2));
      check("x_valid", 32'(x_valid), 32'(occ > 0));
      if (err_len) begin
        check("err_len_expected", 32'(err_got < err_exp), 32'(1));
        err_got++;
      end
      if (occ > 0) f = exp_q[rd_idx];
      else for (int i = 0; i < IN; i++) f[i] = '0;
      check_frame(occ > 0 ? "x_frame" : "x_zero", f);
      if (x_valid && x_ready && occ > 0) rd_idx++;
    end
    if (final_req && !final_done) begin
      check("all_frames_released", 32'(rd_idx), 32'(exp_q.size()));
      check("all_len_errors_seen", 32'(err_got), 32'(err_exp));
      check("beat_timeouts", 32'(timeouts), 32'(0));
      final_done = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    x_ready = 1'b0;
    rst     = 1'b1;
    cur.delete();
    idle(3);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, input bit rel);
    bit ok;
    frame_t f;
    ok      = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    if (rel) x_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      timeouts++;
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (rel) x_ready = 1'b0;
    cur.push_back(d);
    if (last && cur.size() == IN) begin
      for (int i = 0; i < IN; i++) f[i] = cur[i];
      exp_q.push_back(f);
      cur.delete();
    end else if (last || cur.size() == IN) begin
      err_exp++;
      cur.delete();
    end
  endtask

  task automatic send_frame(input int n, input int last_idx, input bit rnd, input bit rel_last);
    logic [WIDTH-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        idle(1);
      end
      d = rnd ? WIDTH'($urandom) : WIDTH'(i);
      send_beat(d, i == last_idx, rel_last && (i == last_idx));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    do_reset();
    send_frame(IN, IN - 1, 0, 0);          // ramp frame, held in ONE
    idle(3);
    send_frame(IN, IN - 1, 1, 0);          // second frame fills -> TWO
    idle(3);
    x_ready = 1'b1; idle(1); x_ready = 1'b0;
    idle(3);
    send_frame(11, 10, 1, 0);              // early s_last
    idle(2);
    send_frame(IN, IN - 1, 1, 0);
    idle(2);
    x_ready = 1'b1; idle(1); x_ready = 1'b0;
    idle(2);
    x_ready = 1'b1; idle(1); x_ready = 1'b0;
    idle(2);
    send_frame(IN, -1, 1, 0);              // missing s_last from EMPTY
    idle(2);
    send_frame(IN, IN - 1, 0, 0);
    send_frame(IN, IN - 1, 1, 1);          // frame end coincides with release
    idle(3);
    send_frame(200, -1, 1, 0);             // reset mid-frame
    do_reset();
    send_frame(IN, IN - 1, 1, 0);
    send_frame(IN, IN - 1, 1, 0);
    idle(2);
    do_reset();                            // reset while in TWO
    send_frame(IN, IN - 1, 1, 0);
    idle(2);
    x_ready = 1'b1; idle(1); x_ready = 1'b0;
    idle(2);

    gaps = 1;
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          int r;
          int k;
          r = $urandom_range(0, 9);
          k = $urandom_range(0, IN - 2);
          if (r < 7)       send_frame(IN, IN - 1, 1, 0);
          else if (r == 7) send_frame(IN, -1, 1, 0);
          else             send_frame(k + 1, k, 1, 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          x_ready = 1'($urandom_range(0, 1));
        end
        x_ready = 1'b0;
      end
    join
    gaps = 0;

    x_ready = 1'b1;
    idle(4);
    x_ready = 1'b0;
    idle(2);
    final_req = 1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
